// File: rtl/rv32im_muldiv_issue.sv
// rtl/rv32im_muldiv_issue.sv - issue/writeback stage in front of the RV32 M-extension mul/div unit
// Define MULDIV_RESULT_CACHE_EN to add a one-entry result cache that skips repeated launches.
module rv32im_muldiv_issue #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk_i,
   input  logic            clear_i,
   input  logic            issue_valid_i,
   output logic            issue_ready_o,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   input  logic [RD_W-1:0] rd_addr_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            wb_valid_o,
   output logic [RD_W-1:0] wb_rd_o,
   output logic [XLEN-1:0] wb_data_o,
   output logic [2:0]      md_operation_o,
   output logic [XLEN-1:0] md_operand1_o,
   output logic [XLEN-1:0] md_operand2_o,
   output logic            md_data_ready_o,
   output logic            md_clear_o,
   input  logic [XLEN-1:0] md_result_i,
   input  logic            md_data_ready_i,
   input  logic            md_busy_i
);

   localparam logic [2:0] F_DIV  = 3'b100;
   localparam logic [2:0] F_DIVU = 3'b101;
   localparam logic [2:0] F_REM  = 3'b110;
   localparam logic [2:0] F_REMU = 3'b111;
   localparam logic [XLEN-1:0] W_MIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [2:0]      r_funct3;
   logic [XLEN-1:0] r_op1;
   logic [XLEN-1:0] r_op2;
   logic [RD_W-1:0] r_rd;
   logic [XLEN-1:0] r_result;

   logic            w_accept;
   logic            w_rs2_zero;
   logic            w_ovf;
   logic            w_special;
   logic [XLEN-1:0] w_special_data;
   logic            w_hit;
   logic [XLEN-1:0] w_hit_data;
   logic            w_capture;

   assign w_accept   = issue_valid_i & (r_state == S_IDLE) & ~flush_i;
   assign w_rs2_zero = (rs2_data_i == '0);
   assign w_ovf      = (rs1_data_i == W_MIN) & (rs2_data_i == '1);
   assign w_capture  = (r_state == S_WAIT) & md_data_ready_i & ~flush_i;

   // RISC-V defines div-by-zero and signed overflow results, so they never reach the unit.
   always_comb begin
      w_special      = 1'b1;
      w_special_data = '0;
      if (rd_addr_i == '0)
         w_special_data = '0;
      else if (((funct3_i == F_DIV) || (funct3_i == F_DIVU)) && w_rs2_zero)
         w_special_data = '1;
      else if (((funct3_i == F_REM) || (funct3_i == F_REMU)) && w_rs2_zero)
         w_special_data = rs1_data_i;
      else if ((funct3_i == F_DIV) && w_ovf)
         w_special_data = W_MIN;
      else if ((funct3_i == F_REM) && w_ovf)
         w_special_data = '0;
      else
         w_special = 1'b0;
   end

`ifdef MULDIV_RESULT_CACHE_EN
   logic            r_c_valid;
   logic [2:0]      r_c_funct3;
   logic [XLEN-1:0] r_c_op1;
   logic [XLEN-1:0] r_c_op2;
   logic [XLEN-1:0] r_c_result;

   assign w_hit      = r_c_valid & (r_c_funct3 == funct3_i) &
                       (r_c_op1 == rs1_data_i) & (r_c_op2 == rs2_data_i);
   assign w_hit_data = r_c_result;

   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         r_c_valid  <= 1'b0;
         r_c_funct3 <= '0;
         r_c_op1    <= '0;
         r_c_op2    <= '0;
         r_c_result <= '0;
      end else if (flush_i) begin
         r_c_valid <= 1'b0;
      end else if (w_capture) begin
         r_c_valid  <= 1'b1;
         r_c_funct3 <= r_funct3;
         r_c_op1    <= r_op1;
         r_c_op2    <= r_op2;
         r_c_result <= md_result_i;
      end
   end
`else
   assign w_hit      = 1'b0;
   assign w_hit_data = '0;
`endif

   always_ff @(posedge clk_i) begin
      if (clear_i)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   always_comb begin
      w_next          = r_state;
      issue_ready_o   = (r_state == S_IDLE);
      stall_o         = issue_valid_i & (r_state != S_IDLE);
      md_data_ready_o = 1'b0;
      md_clear_o      = clear_i;
      wb_valid_o      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_next = (w_special | w_hit) ? S_DONE : S_LAUNCH;
         end
         S_LAUNCH: begin
            stall_o = 1'b1;
            if (flush_i) begin
               md_clear_o = 1'b1;
               w_next     = S_IDLE;
            end else if (!md_busy_i) begin
               md_data_ready_o = ~clear_i;
               w_next          = S_WAIT;
            end
         end
         S_WAIT: begin
            stall_o = 1'b1;
            if (flush_i) begin
               md_clear_o = 1'b1;
               w_next     = S_IDLE;
            end else if (md_data_ready_i) begin
               w_next = S_DONE;
            end
         end
         S_DONE: begin
            wb_valid_o = ~flush_i & ~clear_i;
            w_next     = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Operand registers double as the unit's operand bus, so they hold until the next accept.
   always_ff @(posedge clk_i) begin
      if (clear_i) begin
         r_funct3 <= '0;
         r_op1    <= '0;
         r_op2    <= '0;
         r_rd     <= '0;
         r_result <= '0;
      end else begin
         if (w_accept) begin
            r_funct3 <= funct3_i;
            r_op1    <= rs1_data_i;
            r_op2    <= rs2_data_i;
            r_rd     <= rd_addr_i;
            r_result <= w_special ? w_special_data : w_hit_data;
         end
         if (w_capture)
            r_result <= md_result_i;
      end
   end

   assign md_operation_o = r_funct3;
   assign md_operand1_o  = r_op1;
   assign md_operand2_o  = r_op2;
   assign wb_rd_o        = r_rd;
   assign wb_data_o      = r_result;

endmodule

// File: tb/tb_rv32im_muldiv_issue.sv
// tb/tb_rv32im_muldiv_issue.sv - directed self-checking bench for rv32im_muldiv_issue
// Unit responses are driven by hand; cache scenario runs when MULDIV_RESULT_CACHE_EN is defined.
module tb_rv32im_muldiv_issue;

   logic        clk_i = 1'b0;
   logic        clear_i;
   logic        issue_valid_i;
   logic        issue_ready_o;
   logic [2:0]  funct3_i;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic [4:0]  rd_addr_i;
   logic        flush_i;
   logic        stall_o;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic [31:0] wb_data_o;
   logic [2:0]  md_operation_o;
   logic [31:0] md_operand1_o;
   logic [31:0] md_operand2_o;
   logic        md_data_ready_o;
   logic        md_clear_o;
   logic [31:0] md_result_i;
   logic        md_data_ready_i;
   logic        md_busy_i;

   int n_cmp = 0;
   int n_bad = 0;
   int start_cnt = 0;
   int wb_cnt = 0;
   int consec_cnt = 0;
   logic prev_wb = 1'b0;

   rv32im_muldiv_issue #(.XLEN(32), .RD_W(5)) dut (
      .clk_i(clk_i), .clear_i(clear_i),
      .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
      .funct3_i(funct3_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
      .rd_addr_i(rd_addr_i), .flush_i(flush_i), .stall_o(stall_o),
      .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
      .md_operation_o(md_operation_o), .md_operand1_o(md_operand1_o),
      .md_operand2_o(md_operand2_o), .md_data_ready_o(md_data_ready_o),
      .md_clear_o(md_clear_o), .md_result_i(md_result_i),
      .md_data_ready_i(md_data_ready_i), .md_busy_i(md_busy_i)
   );

   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) begin
      if (md_data_ready_o) start_cnt <= start_cnt + 1;
      if (wb_valid_o) wb_cnt <= wb_cnt + 1;
      if (wb_valid_o && prev_wb) consec_cnt <= consec_cnt + 1;
      prev_wb <= wb_valid_o;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd);
      issue_valid_i = 1'b1;
      funct3_i      = f3;
      rs1_data_i    = a;
      rs2_data_i    = b;
      rd_addr_i     = rd;
   endtask

   task automatic run_special(input string tag, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
      int s0;
      s0 = start_cnt;
      tick(); present(f3, a, b, rd); #1;
      check_eq({tag, "_ready"}, 32'(issue_ready_o), 1);
      tick(); issue_valid_i = 1'b0; #1;
      check_eq({tag, "_wbv"}, 32'(wb_valid_o), 1);
      check_eq({tag, "_rd"}, 32'(wb_rd_o), 32'(rd));
      check_eq({tag, "_data"}, wb_data_o, exp);
      check_eq({tag, "_mdr"}, 32'(md_data_ready_o), 0);
      tick(); #1;
      check_eq({tag, "_wbv_off"}, 32'(wb_valid_o), 0);
      check_eq({tag, "_nostart"}, 32'(start_cnt - s0), 0);
   endtask

   task automatic run_launch(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd, input logic [31:0] res);
      int s0;
      s0 = start_cnt;
      tick(); present(f3, a, b, rd); #1;
      check_eq({tag, "_ready"}, 32'(issue_ready_o), 1);
      tick(); issue_valid_i = 1'b0; #1;
      check_eq({tag, "_mdr"}, 32'(md_data_ready_o), 1);
      check_eq({tag, "_op"}, 32'(md_operation_o), 32'(f3));
      check_eq({tag, "_opa"}, md_operand1_o, a);
      check_eq({tag, "_opb"}, md_operand2_o, b);
      check_eq({tag, "_stall_l"}, 32'(stall_o), 1);
      tick(); md_data_ready_i = 1'b1; md_result_i = res; #1;
      check_eq({tag, "_mdr_off"}, 32'(md_data_ready_o), 0);
      check_eq({tag, "_stall_w"}, 32'(stall_o), 1);
      check_eq({tag, "_wbv_w"}, 32'(wb_valid_o), 0);
      tick(); md_data_ready_i = 1'b0; #1;
      check_eq({tag, "_wbv"}, 32'(wb_valid_o), 1);
      check_eq({tag, "_rd"}, 32'(wb_rd_o), 32'(rd));
      check_eq({tag, "_data"}, wb_data_o, res);
      tick(); #1;
      check_eq({tag, "_wbv_off"}, 32'(wb_valid_o), 0);
      check_eq({tag, "_starts"}, 32'(start_cnt - s0), 1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      int s0;
      clear_i = 1'b1; issue_valid_i = 1'b0; funct3_i = '0; rs1_data_i = '0; rs2_data_i = '0;
      rd_addr_i = '0; flush_i = 1'b0; md_result_i = '0; md_data_ready_i = 1'b0; md_busy_i = 1'b0;
      tick(); tick();
      check_eq("clr_mdclear", 32'(md_clear_o), 1);
      clear_i = 1'b0; #1;
      check_eq("rst_ready", 32'(issue_ready_o), 1);
      check_eq("rst_stall", 32'(stall_o), 0);
      check_eq("rst_wbv", 32'(wb_valid_o), 0);
      check_eq("rst_wbrd", 32'(wb_rd_o), 0);
      check_eq("rst_wbdata", wb_data_o, 0);
      check_eq("rst_mdr", 32'(md_data_ready_o), 0);
      check_eq("rst_mdop", 32'(md_operation_o), 0);
      check_eq("rst_opa", md_operand1_o, 0);
      check_eq("rst_opb", md_operand2_o, 0);
      check_eq("rst_mdclear", 32'(md_clear_o), 0);

      run_launch("divu", 3'b101, 32'd100, 32'd7, 5'd5, 32'd14);
      run_special("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd3, 32'h8000_0000);
      run_special("remu_z", 3'b111, 32'd37, 32'd0, 5'd7, 32'd37);
      run_special("mul_rd0", 3'b000, 32'd6, 32'd7, 5'd0, 32'd0);
      run_special("divu_z", 3'b101, 32'd9, 32'd0, 5'd2, 32'hFFFF_FFFF);
      run_special("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6, 32'd0);

      // REM while the unit is busy for three cycles
      s0 = start_cnt; w0 = wb_cnt;
      tick(); md_busy_i = 1'b1; present(3'b110, 32'd50, 32'd7, 5'd9); #1;
      check_eq("busy_ready", 32'(issue_ready_o), 1);
      for (int i = 0; i < 3; i++) begin
         tick(); issue_valid_i = 1'b0; #1;
         check_eq("busy_hold_mdr", 32'(md_data_ready_o), 0);
         check_eq("busy_hold_stall", 32'(stall_o), 1);
         check_eq("busy_hold_opa", md_operand1_o, 32'd50);
      end
      tick(); md_busy_i = 1'b0; #1;
      check_eq("busy_mdr", 32'(md_data_ready_o), 1);
      check_eq("busy_op", 32'(md_operation_o), 32'd6);
      check_eq("busy_opb", md_operand2_o, 32'd7);
      tick(); md_data_ready_i = 1'b1; md_result_i = 32'd1; #1;
      check_eq("busy_mdr_off", 32'(md_data_ready_o), 0);
      tick(); md_data_ready_i = 1'b0; #1;
      check_eq("busy_wbv", 32'(wb_valid_o), 1);
      check_eq("busy_data", wb_data_o, 32'd1);
      check_eq("busy_rd", 32'(wb_rd_o), 32'd9);
      tick(); #1;
      check_eq("busy_starts", 32'(start_cnt - s0), 1);
      check_eq("busy_wbs", 32'(wb_cnt - w0), 1);

      // flush in WAIT, stray unit response, then an immediate new op
      w0 = wb_cnt;
      tick(); present(3'b011, 32'd2, 32'd3, 5'd4); #1;
      tick(); issue_valid_i = 1'b0; #1;
      check_eq("fl_mdr", 32'(md_data_ready_o), 1);
      tick(); flush_i = 1'b1; #1;
      check_eq("fl_mdclear", 32'(md_clear_o), 1);
      check_eq("fl_wbv", 32'(wb_valid_o), 0);
      tick(); flush_i = 1'b0; md_data_ready_i = 1'b1; md_result_i = 32'd99; #1;
      check_eq("fl_mdclear_off", 32'(md_clear_o), 0);
      check_eq("fl_idle_ready", 32'(issue_ready_o), 1);
      tick(); md_data_ready_i = 1'b0; #1;
      check_eq("fl_stray_wbv", 32'(wb_valid_o), 0);
      check_eq("fl_nowb", 32'(wb_cnt - w0), 0);
      run_launch("after_fl", 3'b000, 32'd6, 32'd7, 5'd8, 32'd42);

      // flush in IDLE blocks acceptance
      s0 = start_cnt;
      tick(); flush_i = 1'b1; present(3'b101, 32'd10, 32'd3, 5'd1); #1;
      tick(); flush_i = 1'b0; issue_valid_i = 1'b0; #1;
      check_eq("idlefl_ready", 32'(issue_ready_o), 1);
      check_eq("idlefl_mdr", 32'(md_data_ready_o), 0);
      check_eq("idlefl_starts", 32'(start_cnt - s0), 0);

`ifdef MULDIV_RESULT_CACHE_EN
      run_launch("c_first", 3'b000, 32'd3, 32'd5, 5'd1, 32'd15);
      run_special("c_hit", 3'b000, 32'd3, 32'd5, 5'd2, 32'd15);
      tick(); clear_i = 1'b1; #1;
      tick(); clear_i = 1'b0; #1;
      run_launch("c_relaunch", 3'b000, 32'd3, 32'd5, 5'd2, 32'd15);
`endif

      check_eq("wb_never_consec", 32'(consec_cnt), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
